// File: rtl/sqrt_scheduler_if.sv
// Request, shared-core and response bundle for sqrt_scheduler.
// master: requesters/core/consumer side; slave: the scheduler.
interface sqrt_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][51:0] req_operand;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     core_start;
    logic [51:0]              core_operand;
    logic [50:0]              core_result;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [50:0]              resp_data;
    logic                     resp_ready;

    modport master (
        output req_valid, req_operand, core_result, resp_ready,
        input  req_ready, core_start, core_operand, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_operand, core_result, resp_ready,
        output req_ready, core_start, core_operand, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/sqrt_scheduler.sv
// Round-robin scheduler sharing one fixed-latency square-root core among NUM_REQ requesters.
// Optional macro SQRT_SCHED_ZERO_BYPASS_EN: zero radicands answer 0 without using the core.
//
// state | meaning
// IDLE  | arbitrate, pulse req_ready to the winner, latch operand and id
// ISSUE | pulse core_start, load latency counter
// WAIT  | count down; capture core_result when the counter hits 1
// RESP  | hold response until resp_ready
module sqrt_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CORE_LATENCY = 16
) (
    input  logic          clk,
    input  logic          rst_,
    sqrt_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [51:0]       core_operand_q, core_operand_d;
    logic [50:0]       resp_data_q, resp_data_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic              core_start;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[wrap_add(ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        resp_id_d      = resp_id_q;
        core_operand_d = core_operand_q;
        resp_data_d    = resp_data_q;
        cnt_d          = cnt_q;
        req_ready      = '0;
        core_start     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    core_operand_d       = bus.req_operand[grant_idx];
                    resp_id_d            = grant_idx;
                    ptr_d                = wrap_add(grant_idx, 1);
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
`ifdef SQRT_SCHED_ZERO_BYPASS_EN
                if (core_operand_q == '0) begin
                    resp_data_d = '0;
                    state_d     = RESP;
                end else begin
                    core_start = 1'b1;
                    cnt_d      = 6'(CORE_LATENCY);
                    state_d    = WAIT;
                end
`else
                core_start = 1'b1;
                cnt_d      = 6'(CORE_LATENCY);
                state_d    = WAIT;
`endif
            end
            WAIT: begin
                // The edge that sees cnt_q == 1 is exactly CORE_LATENCY edges after core_start.
                if (cnt_q == 6'd1) begin
                    resp_data_d = bus.core_result;
                    cnt_d       = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // No accept may be signalled on an edge that is resetting the block.
        if (rst_) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            resp_id_q      <= '0;
            core_operand_q <= '0;
            resp_data_q    <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            resp_id_q      <= resp_id_d;
            core_operand_q <= core_operand_d;
            resp_data_q    <= resp_data_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.core_start   = core_start;
    assign bus.core_operand = core_operand_q;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_data    = resp_data_q;
endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler: vector table plus backpressure, fairness, zero and reset sequences.
module tb_sqrt_scheduler;
    localparam int L = 16;

`ifdef SQRT_SCHED_ZERO_BYPASS_EN
    localparam int ZERO_LAT    = 2;
    localparam int ZERO_STARTS = 0;
`else
    localparam int ZERO_LAT    = L + 2;
    localparam int ZERO_STARTS = 1;
`endif

    logic clk = 1'b0;
    logic rst_;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   age    = 255;
    logic [51:0] model_op = '0;

    sqrt_scheduler_if #(.NUM_REQ(4)) bus ();

    sqrt_scheduler #(.NUM_REQ(4), .CORE_LATENCY(L)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [50:0] isqrt(input logic [51:0] x);
        longint unsigned r;
        longint unsigned t;
        longint unsigned xv;
        r  = 0;
        xv = 64'(x);
        for (int b = 25; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= xv) r = t;
        end
        return r[50:0];
    endfunction

    // Core model: result is only correct on the cycle the scheduler must sample it.
    always @(negedge clk) begin
        if (bus.core_start) begin
            age      <= 0;
            model_op <= bus.core_operand;
            starts   <= starts + 1;
        end else if (age < 255) begin
            age <= age + 1;
        end
    end
    assign bus.core_result = (age == L) ? isqrt(model_op) : ~isqrt(model_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; latency counted from the accept cycle (cycle 0).
    task automatic run_txn(input string name, input logic [3:0] mask, input logic [1:0] exp_id,
                           input logic [50:0] exp_data, input int exp_lat, input int exp_starts);
        int n;
        int s0;
        s0 = starts;
        bus.req_valid = mask;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_grant"}, 64'(bus.req_ready), 64'(4'b1 << exp_id));
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 1;
        while (!bus.resp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_id"}, 64'(bus.resp_id), 64'(exp_id));
        check({name, "_data"}, 64'(bus.resp_data), 64'(exp_data));
        check({name, "_starts"}, 64'(starts - s0), 64'(exp_starts));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({name, "_resp_drop"}, 64'(bus.resp_valid), 64'(0));
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  exp_id;
        logic [50:0] exp_data;
    } vec_t;

    vec_t vecs [8];
    int   ids [5];

    initial begin
        int n;
        int s0;
        int got;
        int bad;
        logic [1:0]  hold_id;
        logic [50:0] hold_data;

        // lane operands: 0x40->8, 0x90->0xC, 1000000->1000, 2^50->2^25
        vecs[0] = '{4'b0001, 2'd0, 51'h8};
        vecs[1] = '{4'b0001, 2'd0, 51'h8};
        vecs[2] = '{4'b0110, 2'd1, 51'hC};
        vecs[3] = '{4'b0110, 2'd2, 51'h3E8};
        vecs[4] = '{4'b1001, 2'd3, 51'h2000000};
        vecs[5] = '{4'b1100, 2'd2, 51'h3E8};
        vecs[6] = '{4'b0100, 2'd2, 51'h3E8};
        vecs[7] = '{4'b0011, 2'd0, 51'h8};

        bus.req_operand[0] = 52'h40;
        bus.req_operand[1] = 52'h90;
        bus.req_operand[2] = 52'd1000000;
        bus.req_operand[3] = 52'h4_0000_0000_0000;
        bus.req_valid  = 4'hF;
        bus.resp_ready = 1'b0;
        rst_ = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_id", 64'(bus.resp_id), 64'(0));
        check("rst_resp_data", 64'(bus.resp_data), 64'(0));
        check("rst_core_operand", 64'(bus.core_operand), 64'(0));
        check("rst_core_start", 64'(bus.core_start), 64'(0));
        bus.req_valid = '0;
        rst_ = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].exp_id, vecs[i].exp_data, L + 2, 1);

        // Fairness: pointer is 1 after vec7, so reset it for a clean 0,1,2,3,0 order.
        rst_ = 1'b1;
        @(posedge clk); #1;
        rst_ = 1'b0;
        for (int k = 0; k < 5; k++) ids[k] = -1;
        bus.req_valid  = 4'hF;
        bus.resp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 5 && n < 400) begin
            @(posedge clk); #1; n++;
            if (bus.resp_valid) begin
                ids[got] = int'(bus.resp_id);
                got++;
                if (got == 5) bus.req_valid = '0;
            end
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            check($sformatf("fair_order%0d", k), 64'(ids[k]), 64'(k % 4));

        // Backpressure on requester 1 (pointer is 1 now).
        bus.req_valid = 4'b0010;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        hold_id   = bus.resp_id;
        hold_data = bus.resp_data;
        check("bp_id", 64'(hold_id), 64'(1));
        check("bp_data", 64'(hold_data), 64'h0C);
        bus.req_valid = 4'hF;
        s0  = starts;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.resp_valid || bus.resp_id !== hold_id || bus.resp_data !== hold_data
                || bus.req_ready !== 4'b0) bad++;
        end
        check("bp_stable_cycles_bad", 64'(bad), 64'(0));
        check("bp_starts", 64'(starts - s0), 64'(0));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(bus.resp_valid), 64'(0));
        check("bp_release_idle_grant", 64'(bus.req_ready), 64'(4'b0100));
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;

        // Zero operand on requester 2.
        bus.req_operand[2] = '0;
        run_txn("zero", 4'b0100, 2'd2, 51'h0, ZERO_LAT, ZERO_STARTS);
        bus.req_operand[2] = 52'd1000000;

        // Reset in WAIT cycle 5 of a requester-2 transaction.
        bus.req_valid = 4'b0100;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        s0 = starts;
        rst_ = 1'b1;
        @(posedge clk); #1;
        check("rw_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rw_resp_id", 64'(bus.resp_id), 64'(0));
        check("rw_resp_data", 64'(bus.resp_data), 64'(0));
        check("rw_core_operand", 64'(bus.core_operand), 64'(0));
        check("rw_core_start", 64'(bus.core_start), 64'(0));
        rst_ = 1'b0;
        bad = 0;
        repeat (2 * L) begin
            @(posedge clk); #1;
            if (bus.resp_valid) bad++;
        end
        check("rw_no_resp", 64'(bad), 64'(0));
        check("rw_no_start", 64'(starts - s0), 64'(0));
        bus.req_valid = 4'hF;
        #1;
        check("rw_grant_ptr0", 64'(bus.req_ready), 64'(4'b0001));
        bus.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_scheduler.md
SQRT_SCHEDULER -- requirements
Module: sqrt_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one square-root core, range 2..8.
REQ-002 Parameter CORE_LATENCY, default 16: cycles from core_start to valid core_result, range 1..63.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester request strobe, held until accepted.
REQ-006 req_operand  input  NUM_REQ x 52  per-requester radicand, stable while req_valid high.
REQ-007 req_ready  output  NUM_REQ  one-hot accept pulse; request i accepted when req_valid[i] & req_ready[i].
REQ-008 core_start  output  1  one-cycle start pulse to shared core.
REQ-009 core_operand  output  52  radicand driven to core, held from issue until result capture.
REQ-010 core_result  input  51  core output, sampled exactly CORE_LATENCY cycles after core_start.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_id  output  log2(NUM_REQ)  index of requester owning the result.
REQ-013 resp_data  output  51  square-root result.
REQ-014 resp_ready  input  1  consumer accepts result when resp_valid & resp_ready.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-016 IDLE: if any req_valid set, grant one requester by round-robin, pulse its req_ready for one cycle, latch operand and id, go to ISSUE; else stay IDLE with req_ready all zero.
REQ-017 Round-robin: search starts at priority pointer, ascending index with wrap; after grant, pointer = granted index + 1 modulo NUM_REQ.
REQ-018 ISSUE: assert core_start for exactly one cycle, load wait counter with CORE_LATENCY, go to WAIT.
REQ-019 WAIT: decrement counter each cycle; when counter reaches 1, capture core_result into resp_data on that edge and go to RESP.
REQ-020 RESP: hold resp_valid, resp_id, resp_data stable until resp_ready; on handshake go to IDLE and drop resp_valid next cycle.
REQ-021 Minimum request-to-response latency: accept cycle + 1 (ISSUE) + CORE_LATENCY cycles; resp_valid rises CORE_LATENCY+2 cycles after the accept edge.
REQ-022 Back-to-back throughput: a new grant occurs no earlier than the cycle after the RESP handshake.
REQ-023 req_ready SHALL be zero in ISSUE, WAIT, RESP; req_valid changes in those states have no effect.
REQ-024 core_operand SHALL remain the latched value through ISSUE and WAIT; don't-care otherwise but held at last value.
REQ-025 A requester deasserting req_valid before grant is simply not selected; no state retained for it.

Reset
REQ-026 On rst_ high at an edge: state IDLE, priority pointer 0, req_ready 0, core_start 0, resp_valid 0, resp_id 0, resp_data 0, core_operand 0, counter 0.
REQ-027 Reset mid-transaction abandons it: no response issued, no further core_start, pointer returns to 0.

Configuration
REQ-028 Macro SQRT_SCHED_ZERO_BYPASS_EN defined: a granted operand equal to zero skips ISSUE/WAIT, no core_start, goes directly to RESP next cycle with resp_data 0 and correct resp_id.
REQ-029 Macro SQRT_SCHED_ZERO_BYPASS_EN undefined: zero operands follow the normal ISSUE/WAIT path like any other value.

Verification
REQ-030 Single request: req_valid=0001, operand 0x40, core model returns 0x8 -> one core_start, resp_valid at accept+CORE_LATENCY+2, resp_id=0, resp_data=0x8.
REQ-031 Fairness: req_valid=1111 held, resp_ready=1 -> grant order 0,1,2,3,0, each id exactly once per four responses.
REQ-032 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid/id/data stable, req_ready stays 0, no core_start; release -> IDLE next cycle.
REQ-033 Reset mid-WAIT: rst_ high at WAIT cycle 5 -> all outputs 0 next cycle, no resp_valid, next grant from requester 0.
REQ-034 Zero operand, requester 2: with SQRT_SCHED_ZERO_BYPASS_EN -> no core_start, resp_valid 2 cycles after accept, resp_id=2, resp_data=0; without -> normal latency, one core_start.
